// File: rtl/instr_memory_if.sv
// Fetch, program-load and CPU-observation signals of the instruction memory.
// The memory uses the slave modport and the CPU/loader side uses the master modport.
interface instr_memory_if;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;
  logic        loaded;
  logic        active;
  logic [31:0] register_v0;
  logic        done;
  logic [31:0] result;
  logic        fault;
  logic [15:0] cycles;

  modport slave (
    input  instr_address, load_valid, load_data, load_last, active, register_v0,
    output instr_readdata, load_ready, loaded, done, result, fault, cycles
  );

  modport master (
    output instr_address, load_valid, load_data, load_last, active, register_v0,
    input  instr_readdata, load_ready, loaded, done, result, fault, cycles
  );
endinterface

// File: rtl/instr_memory.sv
// Loadable instruction ROM for a MIPS-style core.
// The ROM is loaded word by word, serves fetches while the program runs, and halts on a jump to 0 or on a timeout.
module instr_memory #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter logic [15:0] TIMEOUT     = 16'd1000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_enable,
  instr_memory_if.slave bus
);
  localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned PW = $clog2(DEPTH_WORDS + 1);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] wptr, wptr_nxt;
  logic          loaded_q, loaded_nxt;
  logic          done_q, done_nxt;
  logic          fault_q, fault_nxt;
  logic [31:0]   result_q, result_nxt;
  logic [15:0]   cycles_q, cycles_nxt;
  logic [15:0]   cycles_inc;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [29:0]   word_idx;
  logic          in_range;
  logic          readable;
  logic          unused_active;

  // The CPU activity flag is informational only.
  assign unused_active = bus.active;

  assign word_idx = 30'((bus.instr_address - BASE_ADDR) >> 2);
  assign in_range = (bus.instr_address >= BASE_ADDR) && (bus.instr_address[1:0] == 2'b00) &&
                    (word_idx < 30'(DEPTH_WORDS));
  assign readable = (state == S_RUN) && in_range && (word_idx < 30'(wptr));

  // Words not yet loaded read as nop, so stale contents after a reset stay invisible.
  assign bus.instr_readdata = readable ? mem[IW'(word_idx)] : 32'h0000_0000;
  assign bus.load_ready     = (state == S_LOAD);
  assign bus.loaded         = loaded_q;
  assign bus.done           = done_q;
  assign bus.fault          = fault_q;
  assign bus.result         = result_q;
  assign bus.cycles         = cycles_q;

  always_ff @(posedge clk) begin
    if (reset && clk_enable && (state == S_LOAD) && bus.load_valid) begin
      mem[IW'(wptr)] <= bus.load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_LOAD;
      wptr     <= '0;
      loaded_q <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      result_q <= '0;
      cycles_q <= '0;
    end else if (clk_enable) begin
      state    <= state_nxt;
      wptr     <= wptr_nxt;
      loaded_q <= loaded_nxt;
      done_q   <= done_nxt;
      fault_q  <= fault_nxt;
      result_q <= result_nxt;
      cycles_q <= cycles_nxt;
    end
  end

  assign cycles_inc = (cycles_q == 16'hFFFF) ? cycles_q : cycles_q + 16'd1;

  always_comb begin
    state_nxt  = state;
    wptr_nxt   = wptr;
    loaded_nxt = loaded_q;
    done_nxt   = done_q;
    fault_nxt  = fault_q;
    result_nxt = result_q;
    cycles_nxt = cycles_q;
    case (state)
      S_LOAD: begin
        if (bus.load_valid) begin
          wptr_nxt = wptr + PW'(1);
          if (bus.load_last || (wptr_nxt == PW'(DEPTH_WORDS))) begin
            state_nxt  = S_RUN;
            loaded_nxt = 1'b1;
          end
        end
      end
      S_RUN: begin
        cycles_nxt = cycles_inc;
        // A jump to 0 takes priority over a timeout landing on the same edge.
        if (bus.instr_address == 32'h0000_0000) begin
          state_nxt  = S_HALT;
          done_nxt   = 1'b1;
          result_nxt = bus.register_v0;
        end else begin
          if (!in_range) begin
            fault_nxt = 1'b1;
          end
          if (cycles_inc == TIMEOUT) begin
            state_nxt  = S_HALT;
            done_nxt   = 1'b1;
            fault_nxt  = 1'b1;
            result_nxt = bus.register_v0;
          end
        end
      end
      S_HALT: begin
      end
      default: state_nxt = S_LOAD;
    endcase
  end
endmodule

// File: doc/instr_memory.md
INSTR_MEMORY -- requirements
Module: instr_memory

Interface
REQ-001 The parameter DEPTH_WORDS SHALL default to 64 and set the number of 32-bit instruction words stored.
REQ-002 The parameter BASE_ADDR SHALL default to 32'hBFC00000 and set the byte address of stored word 0.
REQ-003 The parameter TIMEOUT SHALL default to 16'd1000 and set the RUN-cycle limit before a forced halt.
REQ-004 The ports SHALL be, one per line, name direction width meaning:
  clk  in  1  single clock, rising edge
  reset  in  1  synchronous reset, active-low
  clk_enable  in  1  qualifies every state/counter update
  instr_address  in  32  CPU fetch byte address
  instr_readdata  out  32  fetched instruction, combinational
  load_valid  in  1  load word offered
  load_ready  out  1  load word accepted this cycle if load_valid
  load_data  in  32  load word
  load_last  in  1  final word of program
  loaded  out  1  program load complete
  active  in  1  CPU active flag, observation only
  register_v0  in  32  CPU $v0 value
  done  out  1  halt reached
  result  out  32  $v0 captured at halt
  fault  out  1  sticky illegal fetch or timeout
  cycles  out  16  RUN-cycle count

Function
REQ-005 The block SHALL have states LOAD, RUN, HALT; updates occur only at rising clk with clk_enable=1 and reset high.
REQ-006 In LOAD, load_ready SHALL be 1; elsewhere 0.
REQ-007 In LOAD, load_valid=1 SHALL write load_data to word wptr and increment wptr (count of loaded words).
REQ-008 LOAD->RUN SHALL occur on the accepted word with load_last=1 or on the accepted word making wptr=DEPTH_WORDS; loaded SHALL be 1 from the next cycle.
REQ-009 load_valid outside LOAD SHALL be ignored, with no write and no pointer change.
REQ-010 index = (instr_address - BASE_ADDR) >> 2; a fetch is in-range when instr_address >= BASE_ADDR, instr_address[1:0]=0, and index < DEPTH_WORDS.
REQ-011 instr_readdata SHALL be mem[index] when state is RUN, in-range, and index < wptr; otherwise 32'h00000000 (nop).
REQ-012 In RUN, an enabled edge with instr_address=0 SHALL move to HALT, set done=1, and latch result=register_v0.
REQ-013 In RUN, an enabled edge with instr_address nonzero and not in-range SHALL set fault=1; state stays RUN.
REQ-014 cycles SHALL increment on each enabled RUN edge, saturating at 16'hFFFF.
REQ-015 When cycles reaches TIMEOUT in RUN, the block SHALL enter HALT with done=1, fault=1, and result=register_v0.
REQ-016 In HALT, result, done, fault, and cycles SHALL hold until reset; fetches return 0.
REQ-017 If halt (REQ-012) and timeout coincide on the same edge, the halt SHALL win: fault is not set by the timeout.
REQ-018 With clk_enable=0, all registers SHALL hold; combinational instr_readdata still follows REQ-011.

Reset
REQ-019 An enabled or disabled rising clk with reset=0 SHALL force state LOAD, wptr=0, loaded=0, done=0, fault=0, result=0, cycles=0.
REQ-020 Memory contents need not clear on reset; words at index >= wptr SHALL read as 0 through REQ-011.
REQ-021 A reset during LOAD or RUN SHALL discard the program; a new load starts at word 0.

Verification
REQ-022 Load sequence: 6 words, last on word 6 (e.g. 24847FFF, 00042400, 2484FFB3, 2882000B, 00000008, 24000000) -> load_ready=1 throughout; loaded=1 next cycle; fetch of BFC0000C returns 2882000B; fetch of BFC00018 returns 0.
REQ-023 Halt: in RUN, drive instr_address=0 with register_v0=32'h00000001 -> next cycle done=1, result=1, fault=0; a later register_v0 change leaves result=1.
REQ-024 Illegal fetches: addresses BFC00002 (misaligned) and 00001000 (out of range) -> readdata=0, fault=1 sticky, done=0.
REQ-025 Overflow load: DEPTH_WORDS=4, 6 words offered with no load_last -> 4 accepted, load_ready=0 after the 4th, words 5-6 ignored.
REQ-026 Timeout: TIMEOUT=10, fetch loop never reaching 0 -> after 10 RUN cycles done=1, fault=1, cycles=10.
REQ-027 Reset mid-RUN: reset=0 for one edge -> loaded=0, cycles=0, all fetches return 0 until reload.
